// File: rtl/paula_audio_mixer_tdm.sv
// rtl/paula_audio_mixer_tdm.sv - time-multiplexed stereo mixer, one channel MAC per clock
// Snapshots all channels on start, then shifts them through a single shared multiplier.
module paula_audio_mixer_tdm #(
  parameter int CHANNELS = 4,
  parameter int SW       = 8,
  parameter int VW       = 7,
  parameter int OW       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CHANNELS*SW-1:0] samples,
  input  logic [CHANNELS*VW-1:0] vols,
  input  logic [CHANNELS-1:0]    route_l,
  input  logic [CHANNELS-1:0]    route_r,
  output logic                   busy,
  output logic                   valid,
  output logic [OW-1:0]          ldatasum,
  output logic [OW-1:0]          rdatasum
);

  localparam int AW = SW + VW + $clog2(CHANNELS);
  localparam int PW = SW + VW;
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {IDLE, MAC} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [CHANNELS*SW-1:0]   r_smp;
  logic [CHANNELS*VW-1:0]   r_vol;
  logic [CHANNELS-1:0]      r_rl;
  logic [CHANNELS-1:0]      r_rr;
  logic [IW-1:0]            r_idx;
  logic signed [AW-1:0]     r_acc_l;
  logic signed [AW-1:0]     r_acc_r;

  logic                     w_last;
  logic [VW-1:0]            w_vol_raw;
  logic [VW-1:0]            w_vol_eff;
  logic signed [PW-1:0]     w_smp_x;
  logic signed [PW-1:0]     w_vol_x;
  logic signed [PW-1:0]     w_prod;
  logic signed [AW-1:0]     w_p_ext;
  logic signed [AW-1:0]     w_sum_l;
  logic signed [AW-1:0]     w_sum_r;
  logic [OW-1:0]            w_sat_l;
  logic [OW-1:0]            w_sat_r;

  assign w_last    = (r_idx == IW'(CHANNELS - 1));
  assign w_vol_raw = r_vol[VW-1:0];
  // Volume MSB means exactly full scale; the low bits are then ignored.
  assign w_vol_eff = w_vol_raw[VW-1] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, w_vol_raw[VW-2:0]};
  assign w_smp_x   = PW'($signed(r_smp[SW-1:0]));
  assign w_vol_x   = PW'(w_vol_eff);
  assign w_prod    = w_smp_x * w_vol_x;
  assign w_p_ext   = AW'(w_prod);
  assign w_sum_l   = r_acc_l + (r_rl[0] ? w_p_ext : '0);
  assign w_sum_r   = r_acc_r + (r_rr[0] ? w_p_ext : '0);

  generate
    if (OW >= AW) begin : g_ext
      assign w_sat_l = OW'(w_sum_l);
      assign w_sat_r = OW'(w_sum_r);
    end else begin : g_clip
      logic [AW-OW:0] w_top_l;
      logic [AW-OW:0] w_top_r;
      assign w_top_l = w_sum_l[AW-1:OW-1];
      assign w_top_r = w_sum_r[AW-1:OW-1];
      // In range only when every bit above the output sign bit matches it.
      assign w_sat_l = (&w_top_l || ~|w_top_l) ? w_sum_l[OW-1:0] :
                       (w_top_l[AW-OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}});
      assign w_sat_r = (&w_top_r || ~|w_top_r) ? w_sum_r[OW-1:0] :
                       (w_top_r[AW-OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}});
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = MAC;
      MAC:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp    <= '0;
      r_vol    <= '0;
      r_rl     <= '0;
      r_rr     <= '0;
      r_idx    <= '0;
      r_acc_l  <= '0;
      r_acc_r  <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      ldatasum <= '0;
      rdatasum <= '0;
    end else begin
      valid <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_smp   <= samples;
          r_vol   <= vols;
          r_rl    <= route_l;
          r_rr    <= route_r;
          r_idx   <= '0;
          r_acc_l <= '0;
          r_acc_r <= '0;
          busy    <= 1'b1;
        end
      end else if (w_last) begin
        ldatasum <= w_sat_l;
        rdatasum <= w_sat_r;
        valid    <= 1'b1;
        busy     <= 1'b0;
      end else begin
        // Channel k+1 moves into the low slot so the multiplier never needs a mux.
        r_acc_l <= w_sum_l;
        r_acc_r <= w_sum_r;
        r_idx   <= r_idx + 1'b1;
        r_smp   <= r_smp >> SW;
        r_vol   <= r_vol >> VW;
        r_rl    <= r_rl >> 1;
        r_rr    <= r_rr >> 1;
      end
    end
  end

endmodule

// File: tb/tb_paula_audio_mixer_tdm.sv
// tb/tb_paula_audio_mixer_tdm.sv - directed self-checking bench for paula_audio_mixer_tdm
// Three instances cover the default build, a narrow 14-bit output and a single channel.
module tb_paula_audio_mixer_tdm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
  logic [31:0] s0 = '0, s1 = '0;
  logic [27:0] v0 = '0, v1 = '0;
  logic [3:0]  rl0 = '0, rr0 = '0, rl1 = '0, rr1 = '0;
  logic [7:0]  s2 = '0;
  logic [6:0]  v2 = '0;
  logic [0:0]  rl2 = '0, rr2 = '0;
  logic        busy0, valid0, busy1, valid1, busy2, valid2;
  logic [15:0] l0, r0, l2, r2;
  logic [13:0] l1, r1;

  paula_audio_mixer_tdm u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .samples(s0), .vols(v0),
    .route_l(rl0), .route_r(rr0), .busy(busy0), .valid(valid0),
    .ldatasum(l0), .rdatasum(r0));

  paula_audio_mixer_tdm #(.OW(14)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .samples(s1), .vols(v1),
    .route_l(rl1), .route_r(rr1), .busy(busy1), .valid(valid1),
    .ldatasum(l1), .rdatasum(r1));

  paula_audio_mixer_tdm #(.CHANNELS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .samples(s2), .vols(v2),
    .route_l(rl2), .route_r(rr2), .busy(busy2), .valid(valid2),
    .ldatasum(l2), .rdatasum(r2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic dut_valid(input int d);
    return (d == 0) ? valid0 : (d == 1) ? valid1 : valid2;
  endfunction

  function automatic logic dut_busy(input int d);
    return (d == 0) ? busy0 : (d == 1) ? busy1 : busy2;
  endfunction

  task automatic set_start(input int d, input logic b);
    if (d == 0) st0 = b;
    else if (d == 1) st1 = b;
    else st2 = b;
  endtask

  // One start pulse; returns edges from E0 to valid and cycles busy was seen high.
  task automatic run_pass(input int d, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    set_start(d, 1'b1);
    tick();
    set_start(d, 1'b0);
    while (!dut_valid(d) && lat < 20) begin
      if (dut_busy(d)) bc++;
      tick();
      lat++;
    end
  endtask

  int lat, bc, nv, t0, t1;
  logic signed [31:0] cap;

  initial begin
    tick();
    tick();
    check("rst_l0", $signed(l0), 0);
    check("rst_busy0", busy0, 0);
    check("rst_valid0", valid0, 0);
    rst_n = 1'b1;
    tick();
    check("idle_r0", $signed(r0), 0);

    // Default mix
    s0 = {8'h10, 8'h20, 8'h40, 8'h7F};
    v0 = {4{7'h40}};
    rl0 = 4'b1001;
    rr0 = 4'b0110;
    run_pass(0, lat, bc);
    check("mix_latency", lat, 4);
    check("mix_busy_cycles", bc, 4);
    check("mix_l", $signed(l0), 9152);
    check("mix_r", $signed(r0), 6144);
    check("mix_busy_done", busy0, 0);
    tick();
    check("mix_valid_pulse", valid0, 0);
    check("mix_hold_l", $signed(l0), 9152);

    // Volume decode
    s0 = {8'h11, 8'h22, 8'h33, 8'h80};
    v0 = {7'h00, 7'h00, 7'h00, 7'h7F};
    rl0 = 4'b0001;
    rr0 = 4'b0000;
    run_pass(0, lat, bc);
    check("vol_full_l", $signed(l0), -8192);
    check("vol_full_r", $signed(r0), 0);
    v0 = {7'h00, 7'h00, 7'h00, 7'h3F};
    run_pass(0, lat, bc);
    check("vol_63_l", $signed(l0), -8064);
    check("vol_63_r", $signed(r0), 0);

    // Saturation at OW=14
    s1 = {4{8'h7F}};
    v1 = {4{7'h40}};
    rl1 = 4'b1111;
    rr1 = 4'b0000;
    run_pass(1, lat, bc);
    check("sat_pos_l", $signed(l1), 8191);
    check("sat_pos_r", $signed(r1), 0);
    s1 = {4{8'h80}};
    run_pass(1, lat, bc);
    check("sat_neg_l", $signed(l1), -8192);

    // Snapshot isolation and ignored start while busy
    s0 = {8'h10, 8'h20, 8'h40, 8'h7F};
    v0 = {4{7'h40}};
    rl0 = 4'b1001;
    rr0 = 4'b0110;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    tick();
    s0 = {8'h80, 8'h80, 8'h80, 8'h80};
    v0 = '0;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    nv = 0;
    cap = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid0) begin
        nv++;
        cap = $signed(l0);
      end
      tick();
    end
    check("snap_valid_count", nv, 1);
    check("snap_l", cap, 9152);
    check("snap_r", $signed(r0), 6144);

    // Continuous start: one result every CHANNELS+1 cycles
    s0 = {8'h10, 8'h20, 8'h40, 8'h7F};
    v0 = {4{7'h40}};
    st0 = 1'b1;
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 30 && t1 < 0; i++) begin
      if (valid0) begin
        if (t0 < 0) t0 = i;
        else t1 = i;
      end
      tick();
    end
    st0 = 1'b0;
    check("b2b_period", t1 - t0, 5);
    for (int i = 0; i < 10 && busy0; i++) tick();
    check("b2b_drained", busy0, 0);

    // Reset mid-pass at E2
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    tick();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_l", $signed(l0), 0);
    check("rst_mid_r", $signed(r0), 0);
    check("rst_mid_valid", valid0, 0);
    check("rst_mid_busy", busy0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_no_result", valid0, 0);
    run_pass(0, lat, bc);
    check("post_rst_latency", lat, 4);
    check("post_rst_l", $signed(l0), 9152);
    check("post_rst_r", $signed(r0), 6144);

    // Single channel
    s2 = 8'hFF;
    v2 = 7'h01;
    rl2 = 1'b1;
    rr2 = 1'b1;
    run_pass(2, lat, bc);
    check("ch1_latency", lat, 1);
    check("ch1_busy_cycles", bc, 1);
    check("ch1_l", $signed(l2), -1);
    check("ch1_r", $signed(r2), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
